mips_mc_control: RTL and testbench

- Parametrised multi-cycle MIPS control unit: FSM plus instruction decode driving the datapath selects (IR, PC, ALU, register file, memory).
- Successor to the fixed 3-exec-state decoder. Adds:
  - variable-latency memory handshake with timeout;
  - start/halt control;
  - a full branch/jump set;
  - a parametrised ALU-op width and wait budget.
- Sits between the IR/register-file datapath and the memory interface.

---
 rtl/mips_ctrl_pkg.sv | 70 +++++++
 rtl/mips_ctrl_alu_dec.sv | 53 +++++
 rtl/mips_mc_control.sv | 214 +++++++++++++++++++++
 tb/tb_mips_mc_control.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_ctrl_pkg                                                         |
// | Shared types and encodings for the multi-cycle MIPS control unit.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_HALTED = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
    OP_BNE   = 6'h05, OP_BGTZ  = 6'h07, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
    OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E,
    OP_LUI   = 6'h0F, OP_LB    = 6'h20, OP_LW    = 6'h23, OP_SW   = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR   = 6'h08,
    FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25,
    FN_XOR  = 6'h26, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B
  } funct_t;

  localparam logic [3:0] c_alu_and  = 4'b0000;
  localparam logic [3:0] c_alu_or   = 4'b0001;
  localparam logic [3:0] c_alu_add  = 4'b0010;
  localparam logic [3:0] c_alu_xor  = 4'b0011;
  localparam logic [3:0] c_alu_sll  = 4'b0100;
  localparam logic [3:0] c_alu_srl  = 4'b0101;
  localparam logic [3:0] c_alu_sub  = 4'b0110;
  localparam logic [3:0] c_alu_slt  = 4'b0111;
  localparam logic [3:0] c_alu_sra  = 4'b1000;
  localparam logic [3:0] c_alu_sltu = 4'b1001;
  localparam logic [3:0] c_alu_lui  = 4'b1010;

  localparam logic [1:0] c_srcb_rt     = 2'b00;
  localparam logic [1:0] c_srcb_four   = 2'b01;
  localparam logic [1:0] c_srcb_imm    = 2'b10;
  localparam logic [1:0] c_srcb_imm_sh = 2'b11;

  localparam logic [1:0] c_pc_alu    = 2'b00;
  localparam logic [1:0] c_pc_aluout = 2'b01;
  localparam logic [1:0] c_pc_jump   = 2'b10;
  localparam logic [1:0] c_pc_rs     = 2'b11;

  localparam logic [1:0] c_br_eq  = 2'b00;
  localparam logic [1:0] c_br_ne  = 2'b01;
  localparam logic [1:0] c_br_gtz = 2'b10;

  localparam logic [1:0] c_dst_rt  = 2'b00;
  localparam logic [1:0] c_dst_rd  = 2'b01;
  localparam logic [1:0] c_dst_r31 = 2'b10;

  localparam logic [1:0] c_m2r_aluout = 2'b00;
  localparam logic [1:0] c_m2r_mem    = 2'b01;
  localparam logic [1:0] c_m2r_pc     = 2'b10;

  localparam logic [1:0] c_err_none    = 2'b00;
  localparam logic [1:0] c_err_timeout = 2'b01;
  localparam logic [1:0] c_err_illegal = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mips_ctrl_alu_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_ctrl_alu_dec                                                     |
// | Combinational opcode/funct decode to ALU code, zero_ext and legality.|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mips_ctrl_alu_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_code,
  output logic       zero_ext,
  output logic       legal
);

  always_comb begin
    alu_code = c_alu_add;
    zero_ext = 1'b0;
    legal    = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: alu_code = c_alu_add;
          FN_SUBU: alu_code = c_alu_sub;
          FN_AND:  alu_code = c_alu_and;
          FN_OR:   alu_code = c_alu_or;
          FN_XOR:  alu_code = c_alu_xor;
          FN_SLT:  alu_code = c_alu_slt;
          FN_SLTU: alu_code = c_alu_sltu;
          FN_SLLV: alu_code = c_alu_sll;
          FN_SRLV: alu_code = c_alu_srl;
          FN_SRAV: alu_code = c_alu_sra;
          FN_JR:   alu_code = c_alu_add;
          default: legal    = 1'b0;
        endcase
      end
      OP_ADDIU:                 alu_code = c_alu_add;
      OP_ANDI:  begin alu_code = c_alu_and; zero_ext = 1'b1; end
      OP_ORI:   begin alu_code = c_alu_or;  zero_ext = 1'b1; end
      OP_XORI:  begin alu_code = c_alu_xor; zero_ext = 1'b1; end
      OP_SLTI:                  alu_code = c_alu_slt;
      OP_SLTIU:                 alu_code = c_alu_sltu;
      OP_LUI:                   alu_code = c_alu_lui;
      OP_LW, OP_LB, OP_SW:      alu_code = c_alu_add;
      OP_BEQ, OP_BNE, OP_BGTZ:  alu_code = c_alu_sub;
      OP_J, OP_JAL:             alu_code = c_alu_add;
      default:                  legal    = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_mc_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_mc_control                                                       |
// | Multi-cycle MIPS control FSM with memory handshake, timeout, halt.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mips_mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 4,
  parameter int WAIT_CNT_W = 8,
  parameter int MAX_WAIT   = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        instr,
  input  logic               mem_ack,
  input  logic               alu_zero,
  input  logic               alu_pos,
  input  logic               rs_is_zero,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_req,
  output logic               mem_write,
  output logic               mem_byte,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               zero_ext,
  output logic [1:0]         pc_src,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         branch_type,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               running,
  output logic [1:0]         err
);

  localparam logic [WAIT_CNT_W-1:0] c_max_wait = WAIT_CNT_W'(MAX_WAIT);
  localparam logic [WAIT_CNT_W-1:0] c_cnt_sat  = '1;

  state_t                r_state, w_next;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [1:0]            r_err, w_err_next;
  logic [5:0]            w_op, w_fn;
  logic [3:0]            w_alu_code;
  logic [ALUOP_W-1:0]    w_dec_op, w_add_op;
  logic                  w_zext, w_legal;
  logic                  w_is_rtype, w_is_jr, w_is_load, w_is_sw, w_is_branch, w_is_jump;
  logic [1:0]            w_btype;
  logic                  w_mem_phase, w_timeout;
  logic                  w_unused;

  assign w_op        = instr[31:26];
  assign w_fn        = instr[5:0];
  assign w_is_rtype  = (w_op == OP_RTYPE);
  assign w_is_jr     = w_is_rtype && (w_fn == FN_JR);
  assign w_is_load   = (w_op == OP_LW) || (w_op == OP_LB);
  assign w_is_sw     = (w_op == OP_SW);
  assign w_is_branch = (w_op == OP_BEQ) || (w_op == OP_BNE) || (w_op == OP_BGTZ);
  assign w_is_jump   = (w_op == OP_J) || (w_op == OP_JAL);
  assign w_btype     = (w_op == OP_BNE) ? c_br_ne : (w_op == OP_BGTZ) ? c_br_gtz : c_br_eq;
  assign w_dec_op    = ALUOP_W'(w_alu_code);
  assign w_add_op    = ALUOP_W'(c_alu_add);

  // Branch resolution lives in the datapath; the flag inputs are not needed here.
  assign w_unused = ^{instr[25:6], alu_zero, alu_pos};

  // A cycle at the limit with an ack present still completes the access.
  assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_timeout   = (MAX_WAIT != 0) && w_mem_phase && !mem_ack && (r_cnt == c_max_wait);

  assign running = (r_state != S_HALTED);
  assign err     = r_err;

  mips_ctrl_alu_dec u_alu_dec (
    .opcode   (w_op),
    .funct    (w_fn),
    .alu_code (w_alu_code),
    .zero_ext (w_zext),
    .legal    (w_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HALTED;
      r_cnt   <= '0;
      r_err   <= c_err_none;
    end else begin
      r_state <= w_next;
      r_err   <= w_err_next;
      if (w_mem_phase && !mem_ack && (w_next == r_state)) begin
        if (r_cnt != c_cnt_sat) r_cnt <= r_cnt + WAIT_CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_err_next    = r_err;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    mem_byte      = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = c_srcb_rt;
    alu_op        = '0;
    zero_ext      = 1'b0;
    pc_src        = c_pc_alu;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_type   = c_br_eq;
    reg_write     = 1'b0;
    reg_dst       = c_dst_rt;
    mem_to_reg    = c_m2r_aluout;
    case (r_state)
      S_HALTED: begin
        if (start) begin
          w_next     = S_FETCH;
          w_err_next = c_err_none;
        end
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = c_srcb_four;
          alu_op    = w_add_op;
          w_next    = S_DECODE;
        end else if (w_timeout) begin
          w_next     = S_HALTED;
          w_err_next = c_err_timeout;
        end
      end
      S_DECODE: begin
        alu_src_b = c_srcb_imm_sh;
        alu_op    = w_add_op;
        if (w_legal) begin
          w_next = S_EXEC;
        end else begin
          w_next     = S_HALTED;
          w_err_next = c_err_illegal;
        end
      end
      S_EXEC: begin
        w_next = S_FETCH;
        if (w_is_jr) begin
          pc_src   = c_pc_rs;
          pc_write = 1'b1;
          if (rs_is_zero) w_next = S_HALTED;
        end else if (w_is_rtype) begin
          alu_src_a = 1'b1;
          alu_src_b = c_srcb_rt;
          alu_op    = w_dec_op;
          w_next    = S_WB;
        end else if (w_is_load || w_is_sw) begin
          alu_src_a = 1'b1;
          alu_src_b = c_srcb_imm;
          alu_op    = w_dec_op;
          w_next    = S_MEM;
        end else if (w_is_branch) begin
          alu_src_a     = 1'b1;
          alu_src_b     = c_srcb_rt;
          alu_op        = w_dec_op;
          pc_src        = c_pc_aluout;
          pc_write_cond = 1'b1;
          branch_type   = w_btype;
        end else if (w_is_jump) begin
          pc_src   = c_pc_jump;
          pc_write = 1'b1;
          if (w_op == OP_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = c_dst_r31;
            mem_to_reg = c_m2r_pc;
          end
        end else begin
          alu_src_a = 1'b1;
          alu_src_b = c_srcb_imm;
          alu_op    = w_dec_op;
          zero_ext  = w_zext;
          w_next    = S_WB;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = w_is_sw;
        mem_byte  = (w_op == OP_LB);
        if (mem_ack) begin
          w_next = w_is_sw ? S_FETCH : S_WB;
        end else if (w_timeout) begin
          w_next     = S_HALTED;
          w_err_next = c_err_timeout;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = w_is_rtype ? c_dst_rd : c_dst_rt;
        mem_to_reg = w_is_load ? c_m2r_mem : c_m2r_aluout;
        w_next     = S_FETCH;
      end
      default: w_next = S_HALTED;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mips_mc_control                                                    |
// | Table vectors, corner sequences and random programs vs a step model. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_mips_mc_control;

  typedef struct packed {
    logic       ir_write, iord, mem_req, mem_write, mem_byte, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       zero_ext;
    logic [1:0] pc_src;
    logic       pc_write, pc_write_cond;
    logic [1:0] branch_type;
    logic       reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       running;
    logic [1:0] err;
  } outs_t;

  typedef struct {
    logic [31:0] ins;
    bit          rsz;
    outs_t       exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, start, mem_ack, alu_zero, alu_pos, rs_is_zero;
  logic [31:0] instr;
  logic ir_write, iord, mem_req, mem_write, mem_byte, alu_src_a, zero_ext;
  logic pc_write, pc_write_cond, reg_write, running;
  logic [1:0] alu_src_b, pc_src, branch_type, reg_dst, mem_to_reg, err;
  logic [3:0] alu_op;

  int checks = 0;
  int failures = 0;
  bit halted;
  logic [1:0] merr;
  vec_t tab[$];

  always #5 clk = ~clk;

  mips_mc_control #(.ALUOP_W(4), .WAIT_CNT_W(8), .MAX_WAIT(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .mem_ack(mem_ack),
    .alu_zero(alu_zero), .alu_pos(alu_pos), .rs_is_zero(rs_is_zero),
    .ir_write(ir_write), .iord(iord), .mem_req(mem_req), .mem_write(mem_write),
    .mem_byte(mem_byte), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .zero_ext(zero_ext), .pc_src(pc_src), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_type(branch_type), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .running(running), .err(err)
  );

  function automatic bit rbit();
    return 1'($urandom);
  endfunction

  function automatic outs_t got_outs();
    outs_t g = '0;
    g.ir_write = ir_write; g.iord = iord; g.mem_req = mem_req; g.mem_write = mem_write;
    g.mem_byte = mem_byte; g.alu_src_a = alu_src_a; g.alu_src_b = alu_src_b;
    g.alu_op = alu_op; g.zero_ext = zero_ext; g.pc_src = pc_src; g.pc_write = pc_write;
    g.pc_write_cond = pc_write_cond; g.branch_type = branch_type; g.reg_write = reg_write;
    g.reg_dst = reg_dst; g.mem_to_reg = mem_to_reg; g.running = running; g.err = err;
    return g;
  endfunction

  task automatic check(input outs_t exp, input string nm);
    outs_t g;
    g = got_outs();
    checks++;
    if (g !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, g, exp);
    end
  endtask

  // Instruction class, ALU code, zero-extend and branch kind straight from the ISA table.
  function automatic void classify(input logic [31:0] ins, output string kind,
                                   output logic [3:0] alu, output bit zx, output logic [1:0] bt);
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    kind = "ILL"; alu = 4'd0; zx = 1'b0; bt = 2'd0;
    if (op == 6'h00) begin
      kind = "R";
      case (fn)
        6'h21: alu = 4'd2;  6'h23: alu = 4'd6;  6'h24: alu = 4'd0;  6'h25: alu = 4'd1;
        6'h26: alu = 4'd3;  6'h2A: alu = 4'd7;  6'h2B: alu = 4'd9;  6'h04: alu = 4'd4;
        6'h06: alu = 4'd5;  6'h07: alu = 4'd8;  6'h08: kind = "JR";
        default: kind = "ILL";
      endcase
    end else begin
      case (op)
        6'h09: begin kind = "I"; alu = 4'd2; end
        6'h0C: begin kind = "I"; alu = 4'd0; zx = 1'b1; end
        6'h0D: begin kind = "I"; alu = 4'd1; zx = 1'b1; end
        6'h0E: begin kind = "I"; alu = 4'd3; zx = 1'b1; end
        6'h0A: begin kind = "I"; alu = 4'd7; end
        6'h0B: begin kind = "I"; alu = 4'd9; end
        6'h0F: begin kind = "I"; alu = 4'd10; end
        6'h20, 6'h23: begin kind = "LD"; alu = 4'd2; end
        6'h2B: begin kind = "SW"; alu = 4'd2; end
        6'h04: begin kind = "BR"; alu = 4'd6; bt = 2'd0; end
        6'h05: begin kind = "BR"; alu = 4'd6; bt = 2'd1; end
        6'h07: begin kind = "BR"; alu = 4'd6; bt = 2'd2; end
        6'h02: kind = "J";
        6'h03: kind = "JAL";
        default: kind = "ILL";
      endcase
    end
  endfunction

  function automatic string kind_of(input logic [31:0] ins);
    string k; logic [3:0] a; bit z; logic [1:0] b;
    classify(ins, k, a, z, b);
    return k;
  endfunction

  function automatic outs_t mk(bit a, logic [1:0] b, logic [3:0] alu, bit zx, logic [1:0] ps,
                               bit pw, bit pwc, logic [1:0] bt, bit rw, logic [1:0] rd,
                               logic [1:0] m2r);
    outs_t e = '0;
    e.alu_src_a = a; e.alu_src_b = b; e.alu_op = alu; e.zero_ext = zx; e.pc_src = ps;
    e.pc_write = pw; e.pc_write_cond = pwc; e.branch_type = bt; e.reg_write = rw;
    e.reg_dst = rd; e.mem_to_reg = m2r; e.running = 1'b1;
    return e;
  endfunction

  // Expected outputs for one step of an instruction: H(alted), F, D, E, M, W.
  function automatic outs_t exp_out(input byte st, input logic [31:0] ins, input bit ack);
    outs_t e = '0;
    string k; logic [3:0] alu; bit zx; logic [1:0] bt;
    classify(ins, k, alu, zx, bt);
    e.err = merr;
    e.running = (st != "H");
    if (st == "F") begin
      e.mem_req = 1'b1;
      if (ack) begin e.ir_write = 1'b1; e.pc_write = 1'b1; e.alu_src_b = 2'd1; e.alu_op = 4'd2; end
    end else if (st == "D") begin
      e.alu_src_b = 2'd3; e.alu_op = 4'd2;
    end else if (st == "E") begin
      if (k == "JR")       begin e.pc_src = 2'd3; e.pc_write = 1'b1; end
      else if (k == "R")   begin e.alu_src_a = 1'b1; e.alu_op = alu; end
      else if (k == "I")   begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = alu; e.zero_ext = zx; end
      else if (k == "LD" || k == "SW") begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = alu; end
      else if (k == "BR")  begin
        e.alu_src_a = 1'b1; e.alu_op = alu; e.pc_src = 2'd1; e.pc_write_cond = 1'b1; e.branch_type = bt;
      end else if (k == "J") begin e.pc_src = 2'd2; e.pc_write = 1'b1; end
      else if (k == "JAL") begin
        e.pc_src = 2'd2; e.pc_write = 1'b1; e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
      end
    end else if (st == "M") begin
      e.mem_req = 1'b1; e.iord = 1'b1; e.mem_write = (k == "SW"); e.mem_byte = (ins[31:26] == 6'h20);
    end else if (st == "W") begin
      e.reg_write = 1'b1; e.reg_dst = (k == "R") ? 2'd1 : 2'd0; e.mem_to_reg = (k == "LD") ? 2'd1 : 2'd0;
    end
    return e;
  endfunction

  task automatic step(input outs_t exp, input bit ack, input bit rsz, input bit st,
                      input logic [31:0] ins, input string nm);
    instr = ins; mem_ack = ack; rs_is_zero = rsz; start = st;
    alu_zero = rbit(); alu_pos = rbit();
    @(negedge clk);
    check(exp, nm);
    @(posedge clk); #1;
  endtask

  task automatic restart();
    step(exp_out("H", instr, 1'b0), rbit(), rbit(), 1'b0, instr, "halt_idle");
    step(exp_out("H", instr, 1'b0), rbit(), rbit(), 1'b1, instr, "halt_start");
    merr = 2'd0; halted = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fd, input int md, input bit rsz,
                           input bit use_tab, input outs_t tab_exp, input string nm);
    string k;
    bit r;
    k = kind_of(ins);
    if (halted) restart();
    for (int i = 0; i < fd; i++) step(exp_out("F", ins, 1'b0), 1'b0, rbit(), rbit(), ins, {nm, "/F"});
    step(exp_out("F", ins, 1'b1), 1'b1, rbit(), rbit(), ins, {nm, "/Fack"});
    r = rbit();
    step(exp_out("D", ins, r), r, rbit(), rbit(), ins, {nm, "/D"});
    if (k == "ILL") begin halted = 1'b1; merr = 2'd2; return; end
    step(use_tab ? tab_exp : exp_out("E", ins, 1'b0), rbit(), rsz, rbit(), ins, {nm, "/E"});
    if (k == "JR" && rsz) begin halted = 1'b1; return; end
    if (k == "LD" || k == "SW") begin
      for (int i = 0; i < md; i++) step(exp_out("M", ins, 1'b0), 1'b0, rbit(), rbit(), ins, {nm, "/M"});
      step(exp_out("M", ins, 1'b1), 1'b1, rbit(), rbit(), ins, {nm, "/Mack"});
    end
    if (k == "R" || k == "I" || k == "LD") begin
      r = rbit();
      step(exp_out("W", ins, r), r, rbit(), rbit(), ins, {nm, "/W"});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base, ins, rnd;
    outs_t zero;
    zero = '0;
    rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0; rs_is_zero = 1'b0;
    alu_zero = 1'b0; alu_pos = 1'b0; instr = 32'h0;
    merr = 2'd0; halted = 1'b1;

    #12;
    check(zero, "reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    tab.push_back('{32'h00851021, 1'b0, mk(1,0,4'd2,0,0,0,0,0,0,0,0), "addu"});
    tab.push_back('{32'h00851023, 1'b0, mk(1,0,4'd6,0,0,0,0,0,0,0,0), "subu"});
    tab.push_back('{32'h00851024, 1'b0, mk(1,0,4'd0,0,0,0,0,0,0,0,0), "and"});
    tab.push_back('{32'h00851025, 1'b0, mk(1,0,4'd1,0,0,0,0,0,0,0,0), "or"});
    tab.push_back('{32'h00851026, 1'b0, mk(1,0,4'd3,0,0,0,0,0,0,0,0), "xor"});
    tab.push_back('{32'h0085102A, 1'b0, mk(1,0,4'd7,0,0,0,0,0,0,0,0), "slt"});
    tab.push_back('{32'h0085102B, 1'b0, mk(1,0,4'd9,0,0,0,0,0,0,0,0), "sltu"});
    tab.push_back('{32'h00851004, 1'b0, mk(1,0,4'd4,0,0,0,0,0,0,0,0), "sllv"});
    tab.push_back('{32'h00851006, 1'b0, mk(1,0,4'd5,0,0,0,0,0,0,0,0), "srlv"});
    tab.push_back('{32'h00851007, 1'b0, mk(1,0,4'd8,0,0,0,0,0,0,0,0), "srav"});
    tab.push_back('{32'h24820005, 1'b0, mk(1,2,4'd2,0,0,0,0,0,0,0,0), "addiu"});
    tab.push_back('{32'h3082FFFF, 1'b0, mk(1,2,4'd0,1,0,0,0,0,0,0,0), "andi"});
    tab.push_back('{32'h3482FFFF, 1'b0, mk(1,2,4'd1,1,0,0,0,0,0,0,0), "ori"});
    tab.push_back('{32'h3882FFFF, 1'b0, mk(1,2,4'd3,1,0,0,0,0,0,0,0), "xori"});
    tab.push_back('{32'h2882FFFF, 1'b0, mk(1,2,4'd7,0,0,0,0,0,0,0,0), "slti"});
    tab.push_back('{32'h2C82FFFF, 1'b0, mk(1,2,4'd9,0,0,0,0,0,0,0,0), "sltiu"});
    tab.push_back('{32'h3C021234, 1'b0, mk(1,2,4'd10,0,0,0,0,0,0,0,0), "lui"});
    tab.push_back('{32'h8C820004, 1'b0, mk(1,2,4'd2,0,0,0,0,0,0,0,0), "lw"});
    tab.push_back('{32'h80820004, 1'b0, mk(1,2,4'd2,0,0,0,0,0,0,0,0), "lb"});
    tab.push_back('{32'hAC820004, 1'b0, mk(1,2,4'd2,0,0,0,0,0,0,0,0), "sw"});
    tab.push_back('{32'h10850003, 1'b0, mk(1,0,4'd6,0,1,0,1,0,0,0,0), "beq"});
    tab.push_back('{32'h14850003, 1'b0, mk(1,0,4'd6,0,1,0,1,1,0,0,0), "bne"});
    tab.push_back('{32'h1C800003, 1'b0, mk(1,0,4'd6,0,1,0,1,2,0,0,0), "bgtz"});
    tab.push_back('{32'h08000010, 1'b0, mk(0,0,4'd0,0,2,1,0,0,0,0,0), "j"});
    tab.push_back('{32'h0C000010, 1'b0, mk(0,0,4'd0,0,2,1,0,0,1,2,2), "jal"});
    tab.push_back('{32'h00800008, 1'b0, mk(0,0,4'd0,0,3,1,0,0,0,0,0), "jr"});
    tab.push_back('{32'h00000008, 1'b1, mk(0,0,4'd0,0,3,1,0,0,0,0,0), "jr_zero"});
    tab.push_back('{32'hFC000000, 1'b0, zero, "ill_op"});
    tab.push_back('{32'h0085103F, 1'b0, zero, "ill_funct"});

    foreach (tab[i]) run_instr(tab[i].ins, 1, 1, tab[i].rsz, 1'b1, tab[i].exp, tab[i].name);

    // Back-to-back ADDU with immediate acks, then LW with a 3-cycle memory wait.
    run_instr(32'h00851021, 0, 0, 1'b0, 1'b0, zero, "addu_fast");
    run_instr(32'h00851021, 0, 0, 1'b0, 1'b0, zero, "addu_fast2");
    run_instr(32'h8C820004, 0, 3, 1'b0, 1'b0, zero, "lw_wait3");
    // Ack arriving exactly at the wait limit still completes.
    run_instr(32'h8C820004, 5, 5, 1'b0, 1'b0, zero, "ack_at_limit");

    // Fetch timeout: no ack at all.
    if (halted) restart();
    for (int i = 0; i <= 5; i++) step(exp_out("F", 32'h0, 1'b0), 1'b0, 1'b0, 1'b0, 32'h0, "timeout_fetch");
    merr = 2'd1; halted = 1'b1;
    restart();
    run_instr(32'h00851021, 0, 0, 1'b0, 1'b0, zero, "after_timeout");

    // Reset while a store waits for memory.
    step(exp_out("F", 32'hAC820004, 1'b1), 1'b1, 1'b0, 1'b0, 32'hAC820004, "rstsw/F");
    step(exp_out("D", 32'hAC820004, 1'b0), 1'b0, 1'b0, 1'b0, 32'hAC820004, "rstsw/D");
    step(exp_out("E", 32'hAC820004, 1'b0), 1'b0, 1'b0, 1'b0, 32'hAC820004, "rstsw/E");
    step(exp_out("M", 32'hAC820004, 1'b0), 1'b0, 1'b0, 1'b0, 32'hAC820004, "rstsw/M");
    #2;
    check(exp_out("M", 32'hAC820004, 1'b0), "rstsw/M_hold");
    rst_n = 1'b0;
    #1;
    check(zero, "rst_mid_mem");
    @(posedge clk); #1;
    rst_n = 1'b1;
    merr = 2'd0; halted = 1'b1;

    for (int n = 0; n < 200; n++) begin
      rnd = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        ins = rnd;
      end else begin
        base = tab[$urandom_range(0, tab.size() - 1)].ins;
        ins = (base[31:26] == 6'h00) ? {base[31:26], rnd[25:6], base[5:0]} : {base[31:26], rnd[25:0]};
      end
      run_instr(ins, $urandom_range(0, 5), $urandom_range(0, 5), ($urandom_range(0, 3) == 0),
                1'b0, zero, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
